// File: rtl/ac_motor_bridge_ctrl.sv
// ac_motor_bridge_ctrl: sine-triangle PWM bridge controller with per-leg dead-time FSMs and a fault latch
module ac_motor_bridge_ctrl #(
    parameter int WIDTH = 24,
    parameter int CHANNELS = 3,
    parameter int DT_BITS = 4
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         ENABLE,
    input  logic [DT_BITS-1:0]           DEAD_TIME,
    input  logic signed [WIDTH-1:0]      TRIANGLE,
    input  logic [CHANNELS*WIDTH-1:0]    SINE,
    input  logic                         FAULT,
    input  logic                         FAULT_CLR,
    output logic [CHANNELS-1:0]          OUT_HI,
    output logic [CHANNELS-1:0]          OUT_LO,
    output logic [CHANNELS-1:0]          EN,
    output logic                         FAULT_LATCHED
);
    typedef enum logic [2:0] {OFF, LOW, DT_RISE, HIGH, DT_FALL} leg_state_t;
    logic signed [WIDTH-1:0]   tri_q;
    logic [CHANNELS*WIDTH-1:0] sine_q;
    logic [CHANNELS-1:0]       demand;
    logic [1:0]                fill;
    logic                      run, leg_run, en_q;
    logic [DT_BITS-1:0]        dt_eff;
    assign run = ENABLE & ~FAULT_LATCHED & ~FAULT;
    // legs stay OFF until both pipeline stages hold post-reset data
    assign leg_run = run & fill[1];
    assign dt_eff = (DEAD_TIME == '0) ? DT_BITS'(1) : DEAD_TIME;
    assign EN = {CHANNELS{en_q}};
    always_ff @(posedge CLK or posedge RESET)
        if (RESET) begin
            tri_q <= '0;
            sine_q <= '0;
            demand <= '0;
            fill <= '0;
            en_q <= 1'b0;
            FAULT_LATCHED <= 1'b0;
        end else begin
            tri_q <= TRIANGLE;
            sine_q <= SINE;
            fill <= {fill[0], 1'b1};
            en_q <= run;
            FAULT_LATCHED <= FAULT | (FAULT_LATCHED & ~FAULT_CLR);
            for (int i = 0; i < CHANNELS; i++)
                demand[i] <= $signed(sine_q[i*WIDTH +: WIDTH]) >= tri_q;
        end
    for (genvar g = 0; g < CHANNELS; g++) begin : leg
        leg_state_t         state;
        logic [DT_BITS-1:0] cnt, dt_len;
        logic               hi, lo;
        assign OUT_HI[g] = hi;
        assign OUT_LO[g] = lo;
        always_ff @(posedge CLK or posedge RESET)
            if (RESET) begin
                state <= OFF;
                cnt <= '0;
                dt_len <= '0;
                hi <= 1'b0;
                lo <= 1'b0;
            end else if (!leg_run) begin
                state <= OFF;
                hi <= 1'b0;
                lo <= 1'b0;
            end else begin
                case (state)
                    OFF: begin
                        state <= demand[g] ? DT_RISE : DT_FALL;
                        cnt <= DT_BITS'(1);
                        dt_len <= dt_eff;
                    end
                    LOW: if (demand[g]) begin
                        state <= DT_RISE;
                        cnt <= DT_BITS'(1);
                        dt_len <= dt_eff;
                        lo <= 1'b0;
                    end
                    HIGH: if (!demand[g]) begin
                        state <= DT_FALL;
                        cnt <= DT_BITS'(1);
                        dt_len <= dt_eff;
                        hi <= 1'b0;
                    end
                    DT_RISE: if (!demand[g]) begin
                        state <= LOW;
                        lo <= 1'b1;
                    end else if (cnt == dt_len) begin
                        state <= HIGH;
                        hi <= 1'b1;
                    end else cnt <= cnt + DT_BITS'(1);
                    DT_FALL: if (demand[g]) begin
                        state <= HIGH;
                        hi <= 1'b1;
                    end else if (cnt == dt_len) begin
                        state <= LOW;
                        lo <= 1'b1;
                    end else cnt <= cnt + DT_BITS'(1);
                    default: begin
                        state <= OFF;
                        hi <= 1'b0;
                        lo <= 1'b0;
                    end
                endcase
            end
    end
endmodule

// File: tb/tb_ac_motor_bridge_ctrl.sv
// tb_ac_motor_bridge_ctrl: directed vectors plus dead-time, reset and PWM sweep sequences
module tb_ac_motor_bridge_ctrl;
    localparam int W = 24;
    localparam int C = 3;
    localparam int D = 4;
    typedef struct {
        logic en;
        logic [D-1:0] dt;
        int s0;
        logic f, fc;
        logic [C-1:0] hi, lo, eo;
        logic fl;
    } vec_t;
    logic CLK = 0, RESET = 1, ENABLE = 1, FAULT = 0, FAULT_CLR = 0;
    logic [D-1:0] DEAD_TIME = 4'd3;
    logic signed [W-1:0] TRIANGLE = '0;
    logic signed [W-1:0] lane [C];
    logic [C*W-1:0] SINE;
    logic [C-1:0] OUT_HI, OUT_LO, EN;
    logic FAULT_LATCHED;
    int passed = 0, total = 0;
    vec_t tbl[$];
    assign SINE = {lane[2], lane[1], lane[0]};
    always #5 CLK = ~CLK;
    ac_motor_bridge_ctrl #(.WIDTH(W), .CHANNELS(C), .DT_BITS(D)) dut (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .DEAD_TIME(DEAD_TIME),
        .TRIANGLE(TRIANGLE), .SINE(SINE), .FAULT(FAULT), .FAULT_CLR(FAULT_CLR),
        .OUT_HI(OUT_HI), .OUT_LO(OUT_LO), .EN(EN), .FAULT_LATCHED(FAULT_LATCHED)
    );
    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask
    task automatic add(input logic e, input logic [D-1:0] d, input int s, input logic f, input logic fc,
                       input logic [C-1:0] h, input logic [C-1:0] l, input logic [C-1:0] eo, input logic fl);
        vec_t v;
        v.en = e; v.dt = d; v.s0 = s; v.f = f; v.fc = fc; v.hi = h; v.lo = l; v.eo = eo; v.fl = fl;
        tbl.push_back(v);
    endtask
    task automatic dead_gap(output int g);
        g = 0;
        while (!OUT_HI[0] && !OUT_LO[0] && g < 40) begin
            g++;
            tick();
        end
    endtask
    initial begin
        int n, g, ov, viol, rises, p;
        int zc [C];
        logic prev;
        for (int i = 0; i < C; i++) lane[i] = -24'sd100;
        for (int k = 0; k < 5; k++) add(1, 3, -100, 0, 0, 3'b000, 3'b000, 3'b111, 0);
        add(1, 3, -100, 0, 0, 3'b000, 3'b111, 3'b111, 0);
        for (int k = 0; k < 2; k++) add(1, 3, 100, 0, 0, 3'b000, 3'b111, 3'b111, 0);
        for (int k = 0; k < 3; k++) add(1, 3, 100, 0, 0, 3'b000, 3'b110, 3'b111, 0);
        for (int k = 0; k < 2; k++) add(1, 3, 100, 0, 0, 3'b001, 3'b110, 3'b111, 0);
        add(1, 3, 100, 1, 0, 3'b000, 3'b000, 3'b000, 1);
        add(1, 3, 100, 1, 1, 3'b000, 3'b000, 3'b000, 1);
        add(1, 3, 100, 0, 0, 3'b000, 3'b000, 3'b000, 1);
        add(1, 3, 100, 0, 1, 3'b000, 3'b000, 3'b000, 0);
        for (int k = 0; k < 3; k++) add(1, 3, 100, 0, 0, 3'b000, 3'b000, 3'b111, 0);
        add(1, 3, 100, 0, 0, 3'b001, 3'b110, 3'b111, 0);
        for (int k = 0; k < 2; k++) add(1, 0, -100, 0, 0, 3'b001, 3'b110, 3'b111, 0);
        add(1, 0, -100, 0, 0, 3'b000, 3'b110, 3'b111, 0);
        add(1, 0, -100, 0, 0, 3'b000, 3'b111, 3'b111, 0);
        add(1, 0, 100, 0, 0, 3'b000, 3'b111, 3'b111, 0);
        add(1, 0, -100, 0, 0, 3'b000, 3'b111, 3'b111, 0);
        add(1, 0, -100, 0, 0, 3'b000, 3'b110, 3'b111, 0);
        for (int k = 0; k < 2; k++) add(1, 0, -100, 0, 0, 3'b000, 3'b111, 3'b111, 0);
        for (int k = 0; k < 2; k++) add(1, 0, 0, 0, 0, 3'b000, 3'b111, 3'b111, 0);
        add(1, 0, 0, 0, 0, 3'b000, 3'b110, 3'b111, 0);
        add(1, 0, 0, 0, 0, 3'b001, 3'b110, 3'b111, 0);
        add(0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0);
        add(1, 0, 0, 0, 0, 3'b000, 3'b000, 3'b111, 0);
        add(1, 0, 0, 0, 0, 3'b001, 3'b110, 3'b111, 0);
        tick();
        tick();
        check("reset hi", 32'(OUT_HI), 0);
        check("reset lo", 32'(OUT_LO), 0);
        check("reset en", 32'(EN), 0);
        check("reset fl", 32'(FAULT_LATCHED), 0);
        RESET = 0;
        foreach (tbl[k]) begin
            ENABLE = tbl[k].en;
            DEAD_TIME = tbl[k].dt;
            lane[0] = W'(tbl[k].s0);
            FAULT = tbl[k].f;
            FAULT_CLR = tbl[k].fc;
            tick();
            check($sformatf("row%0d hi", k + 1), 32'(OUT_HI), 32'(tbl[k].hi));
            check($sformatf("row%0d lo", k + 1), 32'(OUT_LO), 32'(tbl[k].lo));
            check($sformatf("row%0d en", k + 1), 32'(EN), 32'(tbl[k].eo));
            check($sformatf("row%0d fl", k + 1), 32'(FAULT_LATCHED), 32'(tbl[k].fl));
        end
        // asynchronous reset while leg 0 is HIGH, then refill and a 3-cycle dead interval
        DEAD_TIME = 4'd3;
        #2 RESET = 1;
        #1 check("async hi", 32'(OUT_HI), 0);
        check("async lo", 32'(OUT_LO), 0);
        check("async en", 32'(EN), 0);
        #1 RESET = 0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!OUT_HI[0] && !OUT_LO[0] && n < 30);
        check("post reset idle edges", 32'(n), 6);
        check("post reset hi", 32'(OUT_HI), 32'(3'b001));
        check("post reset lo", 32'(OUT_LO), 32'(3'b110));
        // DEAD_TIME change mid-interval affects only the next interval
        DEAD_TIME = 4'd2;
        lane[0] = -24'sd100;
        repeat (3) tick();
        check("dt2 entry", 32'({OUT_HI[0], OUT_LO[0]}), 0);
        DEAD_TIME = 4'd9;
        dead_gap(g);
        check("dt2 gap", 32'(g), 2);
        check("dt2 lo", 32'(OUT_LO[0]), 1);
        lane[0] = 24'sd100;
        repeat (3) tick();
        check("dt9 entry", 32'({OUT_HI[0], OUT_LO[0]}), 0);
        dead_gap(g);
        check("dt9 gap", 32'(g), 9);
        check("dt9 hi", 32'(OUT_HI[0]), 1);
        // three-phase sweep: no shoot-through, no short dead gaps
        DEAD_TIME = 4'd3;
        ov = 0;
        viol = 0;
        rises = 0;
        prev = OUT_HI[0];
        for (int i = 0; i < C; i++) zc[i] = 0;
        for (int t = 0; t < 2560; t++) begin
            p = t % 256;
            TRIANGLE = W'(p < 128 ? -1024 + p * 16 : 1024 - (p - 128) * 16);
            for (int i = 0; i < C; i++)
                lane[i] = W'($rtoi(900.0 * $sin(2.0 * 3.14159265 * t / 2560.0 + i * 2.0 * 3.14159265 / 3.0)));
            tick();
            for (int i = 0; i < C; i++) begin
                if (OUT_HI[i] && OUT_LO[i]) ov++;
                if (!OUT_HI[i] && !OUT_LO[i]) zc[i]++;
                else begin
                    if (zc[i] > 0 && zc[i] < 3) viol++;
                    zc[i] = 0;
                end
            end
            if (OUT_HI[0] && !prev) rises++;
            prev = OUT_HI[0];
        end
        check("sweep overlap", 32'(ov), 0);
        check("sweep short gaps", 32'(viol), 0);
        check("sweep pwm active", 32'(rises >= 8), 1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
